// File: rtl/quiz_pkg.sv
// Shared types for the four-player buzzer round controller.
package quiz_pkg;

    localparam int NUM_PLAYERS = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        ANSWER = 2'd2
    } state_t;

    typedef logic [1:0] player_t;
    typedef logic [3:0] score_t;

    function automatic logic [NUM_PLAYERS-1:0] player_mask(input player_t p);
        return (NUM_PLAYERS)'(1) << p;
    endfunction

endpackage

// File: rtl/quiz_round_controller_rr_arbiter4.sv
// Combinational four-way round-robin arbiter: first requester at or after ptr.
module rr_arbiter4
    import quiz_pkg::*;
(
    input  logic [NUM_PLAYERS-1:0] req,
    input  player_t                ptr,
    output logic                   grant_valid,
    output player_t                grant_id
);

    player_t idx;

    // Walk offsets from farthest to nearest so the nearest requester wins last.
    always_comb begin
        grant_valid = |req;
        grant_id    = ptr;
        idx         = ptr;
        for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
            idx = ptr + player_t'(i);
            if (req[idx]) begin
                grant_id = idx;
            end
        end
    end

endmodule

// File: rtl/quiz_round_controller.sv
// Buzzer round controller: button sync/edge detect, first-press arbitration,
// answer countdown, host judgement and per-player saturating scores.
//
// state  | meaning
// IDLE   | no question open; host may arm or start a new game
// ARMED  | question open; first eligible press wins
// ANSWER | winner answering; countdown runs until judgement or timeout
module quiz_round_controller
    import quiz_pkg::*;
#(
    parameter int ANSWER_TICKS = 10,
    parameter int SCORE_MAX    = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic [3:0]  player,
    input  logic        host_arm,
    input  logic        host_correct,
    input  logic        host_wrong,
    input  logic        host_new_game,
    output logic [1:0]  state,
    output logic        winner_valid,
    output logic [1:0]  winner_id,
    output logic [3:0]  digit,
    output logic [3:0]  lockout,
    output logic [3:0]  time_left,
    output logic [15:0] scores
);

    localparam logic [3:0] TICKS_INIT = 4'(ANSWER_TICKS);
    localparam score_t     SCORE_CAP  = score_t'(SCORE_MAX);

    state_t                        state_q;
    player_t                       pointer;
    score_t [NUM_PLAYERS-1:0]      score_q;
    logic   [NUM_PLAYERS-1:0]      sync1;
    logic   [NUM_PLAYERS-1:0]      sync2;
    logic   [NUM_PLAYERS-1:0]      prev;
    logic   [NUM_PLAYERS-1:0]      press;
    logic   [NUM_PLAYERS-1:0]      eligible;
    logic   [NUM_PLAYERS-1:0]      lock_next;
    logic                          grant_valid;
    player_t                       grant_id;
    logic                          judge_ok;
    logic                          judge_bad;
    logic                          timeout;

    // Buttons are active-low; flops reset to 1 so nothing looks pressed after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '1;
            sync2 <= '1;
            prev  <= '1;
        end else begin
            sync1 <= player;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign press     = ~sync2 & prev;
    assign eligible  = press & ~lockout;
    assign lock_next = lockout | player_mask(winner_id);

    // Conflicting host strobes cancel; a correct call beats the final tick.
    assign judge_ok  = host_correct & ~host_wrong;
    assign judge_bad = host_wrong & ~host_correct;
    assign timeout   = tick && (time_left == 4'd1);

    rr_arbiter4 u_arb (
        .req         (eligible),
        .ptr         (pointer),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            winner_valid <= 1'b0;
            winner_id    <= '0;
            digit        <= '0;
            lockout      <= '0;
            time_left    <= '0;
            score_q      <= '0;
            pointer      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (host_new_game) begin
                        score_q <= '0;
                        lockout <= '0;
                        pointer <= '0;
                    end
                    if (host_arm) begin
                        lockout <= '0;
                        state_q <= ARMED;
                    end
                end
                ARMED: begin
                    if (grant_valid) begin
                        winner_id    <= grant_id;
                        pointer      <= grant_id + player_t'(1);
                        time_left    <= TICKS_INIT;
                        winner_valid <= 1'b1;
                        digit        <= {2'b00, grant_id} + 4'd1;
                        state_q      <= ANSWER;
                    end
                end
                ANSWER: begin
                    if (judge_ok) begin
                        if (score_q[winner_id] < SCORE_CAP) begin
                            score_q[winner_id] <= score_q[winner_id] + score_t'(1);
                        end
                        time_left    <= '0;
                        winner_valid <= 1'b0;
                        digit        <= '0;
                        state_q      <= IDLE;
                    end else if (judge_bad || timeout) begin
                        lockout      <= lock_next;
                        time_left    <= '0;
                        winner_valid <= 1'b0;
                        digit        <= '0;
                        state_q      <= (&lock_next) ? IDLE : ARMED;
                    end else if (tick) begin
                        time_left <= time_left - 4'd1;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    winner_valid <= 1'b0;
                    digit        <= '0;
                    time_left    <= '0;
                end
            endcase
        end
    end

    assign state  = state_q;
    assign scores = score_q;

endmodule

// File: tb/tb_quiz_round_controller.sv
// Bench for quiz_round_controller: directed scenarios plus random traffic
// checked against a round-level reference model.
module tb_quiz_round_controller;

    localparam int AT = 3;
    localparam int SM = 9;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        tick = 1'b0;
    logic [3:0]  player = 4'hF;
    logic        host_arm = 1'b0;
    logic        host_correct = 1'b0;
    logic        host_wrong = 1'b0;
    logic        host_new_game = 1'b0;
    logic [1:0]  state;
    logic        winner_valid;
    logic [1:0]  winner_id;
    logic [3:0]  digit;
    logic [3:0]  lockout;
    logic [3:0]  time_left;
    logic [15:0] scores;

    int n_checks = 0;
    int n_fail = 0;

    int         m_state;
    int         m_win;
    logic [3:0] m_lock;
    int         m_score [4];
    int         m_ptr;
    int         m_time;
    logic [3:0] hist [3];
    logic [32:0] exp_bus;
    logic [32:0] dut_bus;

    quiz_round_controller #(
        .ANSWER_TICKS (AT),
        .SCORE_MAX    (SM)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .tick          (tick),
        .player        (player),
        .host_arm      (host_arm),
        .host_correct  (host_correct),
        .host_wrong    (host_wrong),
        .host_new_game (host_new_game),
        .state         (state),
        .winner_valid  (winner_valid),
        .winner_id     (winner_id),
        .digit         (digit),
        .lockout       (lockout),
        .time_left     (time_left),
        .scores        (scores)
    );

    always #5 clk = ~clk;

    assign dut_bus = {state, winner_valid, winner_id, digit, lockout, time_left, scores};

    // Round-level model; hist[n] holds the raw buttons sampled n+1 edges ago.
    task automatic model_update();
        logic [3:0] press;
        logic [3:0] elig;
        bit c, w, to;
        if (reset) begin
            m_state = 0; m_win = 0; m_lock = 4'h0; m_ptr = 0; m_time = 0;
            foreach (m_score[k]) m_score[k] = 0;
            foreach (hist[k]) hist[k] = 4'hF;
        end else begin
            press = ~hist[1] & hist[2];
            case (m_state)
                0: begin
                    if (host_new_game) begin
                        foreach (m_score[k]) m_score[k] = 0;
                        m_lock = 4'h0; m_ptr = 0;
                    end
                    if (host_arm) begin
                        m_lock = 4'h0; m_state = 1;
                    end
                end
                1: begin
                    elig = press & ~m_lock;
                    if (elig != 4'h0) begin
                        for (int i = 0; i < 4; i++) begin
                            if (elig[(m_ptr + i) % 4]) begin
                                m_win = (m_ptr + i) % 4;
                                break;
                            end
                        end
                        m_ptr = (m_win + 1) % 4;
                        m_time = AT;
                        m_state = 2;
                    end
                end
                default: begin
                    c  = host_correct && !host_wrong;
                    w  = host_wrong && !host_correct;
                    to = tick && (m_time == 1);
                    if (c) begin
                        if (m_score[m_win] < SM) m_score[m_win]++;
                        m_time = 0; m_state = 0;
                    end else if (w || to) begin
                        m_lock[m_win] = 1'b1;
                        m_time = 0;
                        m_state = (m_lock == 4'hF) ? 0 : 1;
                    end else if (tick) begin
                        m_time--;
                    end
                end
            endcase
            hist[2] = hist[1];
            hist[1] = hist[0];
        end
        hist[0] = reset ? 4'hF : player;
        exp_bus = {2'(m_state), (m_state == 2), 2'(m_win),
                   (m_state == 2) ? 4'(m_win + 1) : 4'd0, m_lock, 4'(m_time),
                   4'(m_score[3]), 4'(m_score[2]), 4'(m_score[1]), 4'(m_score[0])};
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        reset = 0; tick = 0; host_arm = 0; host_correct = 0;
        host_wrong = 0; host_new_game = 0;
    endtask

    task automatic press_only(input int k);
        player = 4'hF;
        repeat (3) step();
        player = ~(4'b0001 << k);
        repeat (3) step();
    endtask

    task automatic test_reset();
        reset = 1;
        step();
        n_checks++;
        if (dut_bus !== 33'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want %h", dut_bus, 33'h0);
        end
        repeat (3) step();
    endtask

    task automatic test_first_press();
        host_arm = 1;
        step();
        n_checks++;
        if (state !== 2'd1) begin
            n_fail++;
            $display("FAIL arm_state: got %0d want 1", state);
        end
        player = 4'b1110;
        step();
        step();
        n_checks++;
        if (winner_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL press_early: winner_valid got %b want 0 after 2 edges", winner_valid);
        end
        step();
        n_checks++;
        if ({winner_valid, winner_id, digit, time_left, state} !== {1'b1, 2'd0, 4'd1, 4'(AT), 2'd2}) begin
            n_fail++;
            $display("FAIL first_capture: valid/id/digit/time/state got %b/%0d/%0d/%0d/%0d want 1/0/1/%0d/2",
                     winner_valid, winner_id, digit, time_left, state, AT);
        end
        host_correct = 1;
        step();
        n_checks++;
        if ({state, scores} !== {2'd0, 16'h0001}) begin
            n_fail++;
            $display("FAIL first_score: state/scores got %0d/%h want 0/0001", state, scores);
        end
        player = 4'hF;
        repeat (3) step();
    endtask

    task automatic test_round_robin_lockout();
        host_arm = 1;
        step();
        player = 4'b1010;
        repeat (3) step();
        n_checks++;
        if ({winner_valid, winner_id, digit} !== {1'b1, 2'd2, 4'd3}) begin
            n_fail++;
            $display("FAIL rr_winner: valid/id/digit got %b/%0d/%0d want 1/2/3", winner_valid, winner_id, digit);
        end
        host_wrong = 1;
        step();
        n_checks++;
        if ({state, lockout, winner_valid, digit} !== {2'd1, 4'b0100, 1'b0, 4'd0}) begin
            n_fail++;
            $display("FAIL wrong_lockout: state/lockout/valid/digit got %0d/%b/%b/%0d want 1/0100/0/0",
                     state, lockout, winner_valid, digit);
        end
        press_only(2);
        repeat (3) step();
        n_checks++;
        if ({state, winner_valid} !== {2'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL locked_repress: state/valid got %0d/%b want 1/0", state, winner_valid);
        end
        player = 4'b0011;
        repeat (3) step();
        n_checks++;
        if ({winner_valid, winner_id, digit} !== {1'b1, 2'd3, 4'd4}) begin
            n_fail++;
            $display("FAIL after_lock_winner: valid/id/digit got %b/%0d/%0d want 1/3/4", winner_valid, winner_id, digit);
        end
        host_correct = 1;
        step();
        n_checks++;
        if (scores !== 16'h1001) begin
            n_fail++;
            $display("FAIL rr_scores: got %h want 1001", scores);
        end
        player = 4'hF;
        repeat (3) step();
    endtask

    task automatic test_timeout();
        logic [3:0] want_lock;
        host_arm = 1;
        step();
        for (int k = 0; k < 4; k++) begin
            press_only(k);
            n_checks++;
            if ({winner_id, time_left} !== {2'(k), 4'd3}) begin
                n_fail++;
                $display("FAIL timeout_capture%0d: id/time got %0d/%0d want %0d/3", k, winner_id, time_left, k);
            end
            for (int t = 2; t >= 1; t--) begin
                tick = 1;
                step();
                step();
                n_checks++;
                if (time_left !== 4'(t)) begin
                    n_fail++;
                    $display("FAIL countdown%0d: time_left got %0d want %0d", k, time_left, t);
                end
            end
            tick = 1;
            step();
            want_lock = 4'((1 << (k + 1)) - 1);
            n_checks++;
            if ({lockout, state, winner_valid} !== {want_lock, (k == 3) ? 2'd0 : 2'd1, 1'b0}) begin
                n_fail++;
                $display("FAIL timeout_lock%0d: lockout/state/valid got %b/%0d/%b want %b/%0d/0",
                         k, lockout, state, winner_valid, want_lock, (k == 3) ? 0 : 1);
            end
        end
        player = 4'hF;
        repeat (3) step();
    endtask

    task automatic test_saturation();
        host_new_game = 1;
        step();
        for (int r = 0; r < 11; r++) begin
            host_arm = 1;
            step();
            press_only(1);
            host_correct = 1;
            step();
        end
        n_checks++;
        if (scores !== 16'h0090) begin
            n_fail++;
            $display("FAIL saturation: scores got %h want 0090", scores);
        end
        host_new_game = 1;
        step();
        n_checks++;
        if ({scores, lockout} !== 20'h0) begin
            n_fail++;
            $display("FAIL new_game: scores/lockout got %h/%b want 0000/0000", scores, lockout);
        end
        n_checks++;
        if (dut_bus !== exp_bus) begin
            n_fail++;
            $display("FAIL model_after_sat: got %h want %h", dut_bus, exp_bus);
        end
        player = 4'hF;
        repeat (3) step();
    endtask

    task automatic test_held_button();
        player = 4'b1110;
        repeat (4) step();
        host_arm = 1;
        step();
        repeat (10) step();
        n_checks++;
        if ({state, winner_valid} !== {2'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL held_no_capture: state/valid got %0d/%b want 1/0", state, winner_valid);
        end
        press_only(0);
        n_checks++;
        if ({winner_valid, winner_id} !== {1'b1, 2'd0}) begin
            n_fail++;
            $display("FAIL held_repress: valid/id got %b/%0d want 1/0", winner_valid, winner_id);
        end
    endtask

    task automatic test_reset_mid_round();
        tick = 1;
        step();
        reset = 1;
        step();
        n_checks++;
        if (dut_bus !== 33'h0) begin
            n_fail++;
            $display("FAIL reset_mid: got %h want %h", dut_bus, 33'h0);
        end
        player = 4'hF;
        repeat (3) step();
    endtask

    task automatic test_random();
        reset = 1;
        step();
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 5) == 0) player[$urandom_range(0, 3)] = ~player[$urandom_range(0, 3)];
            tick          = ($urandom_range(0, 5) == 0);
            host_arm      = ($urandom_range(0, 7) == 0);
            host_correct  = ($urandom_range(0, 24) == 0);
            host_wrong    = ($urandom_range(0, 14) == 0);
            host_new_game = ($urandom_range(0, 59) == 0);
            reset         = ($urandom_range(0, 499) == 0);
            step();
            n_checks++;
            if (dut_bus !== exp_bus) begin
                n_fail++;
                $display("FAIL random_cycle%0d: got %h want %h", n, dut_bus, exp_bus);
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_press();
        test_round_robin_lockout();
        test_timeout();
        test_saturation();
        test_held_button();
        test_reset_mid_round();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
